// File: rtl/bus_transfer_decoder_if.sv
// Bus-transfer sequencer handshake: request side (start + encoded codes)
// and the decoded one-hot enables / status pulses coming back.
interface bus_transfer_decoder_if;
  logic        start;
  logic [4:0]  src_code;
  logic [4:0]  dst_code;
  logic [23:0] src_onehot;
  logic [23:0] dst_onehot;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, src_code, dst_code,
    input  src_onehot, dst_onehot, busy, done, err
  );

  modport slave (
    input  start, src_code, dst_code,
    output src_onehot, dst_onehot, busy, done, err
  );
endinterface

// File: rtl/bus_transfer_decoder.sv
// Sequences one register-to-register transfer over the shared datapath bus:
// latch codes, drive the source for SETTLE_CYCLES, pulse the destination
// load enable for one cycle, then report done. Bad codes give a one-cycle err.
module bus_transfer_decoder #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                   i_clock,
  input logic                   i_clear,
  bus_transfer_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WRITE, S_ERROR} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [4:0]  r_src, w_src_nxt;
  logic [4:0]  r_dst, w_dst_nxt;
  logic [23:0] r_src_oh, w_src_oh_nxt;
  logic [23:0] r_dst_oh, w_dst_oh_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        w_src_ok, w_dst_ok;

  // Code c in 1..24 maps to bit c-1; anything else decodes to zero.
  function automatic logic [23:0] decode(input logic [4:0] code);
    logic [23:0] oh;
    oh = '0;
    for (int i = 0; i < 24; i++) oh[i] = (code == 5'(i + 1));
    return oh;
  endfunction

  // Source must name a real bus driver; destination must also be writable
  // (ZHI, ZLO, Inport and C are read-only).
  always_comb begin
    w_src_ok = (bus.src_code >= 5'd1) && (bus.src_code <= 5'd24);
    w_dst_ok = (bus.dst_code >= 5'd1) && (bus.dst_code <= 5'd24) &&
               (bus.dst_code != 5'd19) && (bus.dst_code != 5'd20) &&
               (bus.dst_code != 5'd23) && (bus.dst_code != 5'd24);
  end

  // Next state plus next value of every registered output.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_src_oh_nxt = '0;
    w_dst_oh_nxt = '0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_src_nxt = bus.src_code;
          w_dst_nxt = bus.dst_code;
          w_busy_nxt = 1'b1;
          if (w_src_ok && w_dst_ok) begin
            w_state_nxt  = S_DRIVE;
            w_cnt_nxt    = CNT_LOAD;
            w_src_oh_nxt = decode(bus.src_code);
          end else begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        w_busy_nxt   = 1'b1;
        w_src_oh_nxt = decode(r_src);
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_WRITE;
          w_dst_oh_nxt = decode(r_dst);
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      S_ERROR: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and latched codes; clear wins over any in-flight transfer.
  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_src   <= 5'd0;
      r_dst   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
    end
  end

  // Output registers, so nothing combinational reaches the ports.
  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_src_oh <= '0;
      r_dst_oh <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_src_oh <= w_src_oh_nxt;
      r_dst_oh <= w_dst_oh_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.src_onehot = r_src_oh;
  assign bus.dst_onehot = r_dst_oh;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_bus_transfer_decoder.sv
// Randomised + directed bench for bus_transfer_decoder. Two instances
// (SETTLE 1 and 3) share stimulus; a transfer-timeline model predicts outputs.
module tb_bus_transfer_decoder;

  logic       clk = 1'b0;
  logic       clear;
  logic       start;
  logic [4:0] src, dst;

  always #5 clk = ~clk;

  bus_transfer_decoder_if bif1 ();
  bus_transfer_decoder_if bif3 ();

  assign bif1.start = start;  assign bif1.src_code = src;  assign bif1.dst_code = dst;
  assign bif3.start = start;  assign bif3.src_code = src;  assign bif3.dst_code = dst;

  bus_transfer_decoder #(.SETTLE_CYCLES(1)) u_s1 (.i_clock(clk), .i_clear(clear), .bus(bif1));
  bus_transfer_decoder #(.SETTLE_CYCLES(3)) u_s3 (.i_clock(clk), .i_clear(clear), .bus(bif3));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a transfer is accepted at edge a; outputs after edge k are a
  // function of the offset k-a and whether the request was valid.
  int         settle [2] = '{1, 3};
  int         acc_at [2];
  bit         active [2];
  bit         good   [2];
  logic [4:0] lsrc   [2];
  logic [4:0] ldst   [2];
  int         k = 0;

  function automatic logic [23:0] onehot(input logic [4:0] c);
    return (c >= 1 && c <= 24) ? (24'd1 << (c - 1)) : 24'd0;
  endfunction

  function automatic bit req_ok(input logic [4:0] s, input logic [4:0] d);
    bit s_ok, d_ok;
    s_ok = (s >= 1 && s <= 24);
    d_ok = (d >= 1 && d <= 24) && !(d inside {5'd19, 5'd20, 5'd23, 5'd24});
    return s_ok && d_ok;
  endfunction

  task automatic model_edge(input int d);
    bit idle;
    if (!clear) begin
      active[d] = 0;
    end else begin
      idle = !active[d] || (good[d] ? (k - acc_at[d] > settle[d] + 1) : (k - acc_at[d] > 1));
      if (idle && start) begin
        active[d] = 1;
        acc_at[d] = k;
        lsrc[d]   = src;
        ldst[d]   = dst;
        good[d]   = req_ok(src, dst);
      end
    end
  endtask

  task automatic compare(input int d);
    logic [23:0] e_src, e_dst, o_src, o_dst;
    logic [2:0]  e_flg, o_flg;  // busy, done, err
    int off;
    e_src = '0; e_dst = '0; e_flg = '0;
    off = k - acc_at[d];
    if (active[d]) begin
      if (good[d]) begin
        if (off < settle[d]) begin
          e_src = onehot(lsrc[d]); e_flg = 3'b100;
        end else if (off == settle[d]) begin
          e_src = onehot(lsrc[d]); e_dst = onehot(ldst[d]); e_flg = 3'b100;
        end else if (off == settle[d] + 1) begin
          e_flg = 3'b010;
        end
      end else if (off == 0) begin
        e_flg = 3'b101;
      end
    end
    if (d == 0) begin
      o_src = bif1.src_onehot; o_dst = bif1.dst_onehot;
      o_flg = {bif1.busy, bif1.done, bif1.err};
    end else begin
      o_src = bif3.src_onehot; o_dst = bif3.dst_onehot;
      o_flg = {bif3.busy, bif3.done, bif3.err};
    end
    chk($sformatf("S%0d cyc%0d src_onehot", settle[d], k), 32'(o_src), 32'(e_src));
    chk($sformatf("S%0d cyc%0d dst_onehot", settle[d], k), 32'(o_dst), 32'(e_dst));
    chk($sformatf("S%0d cyc%0d busy/done/err", settle[d], k), 32'(o_flg), 32'(e_flg));
  endtask

  // One clock: model sees the inputs present at the edge; compare mid-cycle.
  task automatic cycle(input bit c, input bit s, input logic [4:0] sc, input logic [4:0] dc);
    clear = c; start = s; src = sc; dst = dc;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) compare(d);
    k++;
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; src = '0; dst = '0;
    for (int d = 0; d < 2; d++) begin active[d] = 0; acc_at[d] = 0; good[d] = 0; end
    @(negedge clk);

    // reset held with a pending request
    repeat (2) cycle(0, 1, 5'd5, 5'd3);
    cycle(1, 0, 0, 0);

    // PC -> MDR, then HI -> R0
    cycle(1, 1, 5'd21, 5'd22);
    repeat (6) cycle(1, 0, 0, 0);
    cycle(1, 1, 5'd17, 5'd1);
    repeat (6) cycle(1, 0, 0, 0);

    // reject cases
    cycle(1, 1, 5'd0,  5'd3);  repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 5'd25, 5'd3);  repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 5'd4,  5'd31); repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 5'd4,  5'd19); repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 5'd4,  5'd24); repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 5'd7,  5'd7);  repeat (6) cycle(1, 0, 0, 0);

    // start held: fixed codes, then codes churning every cycle
    repeat (8) cycle(1, 1, 5'd2, 5'd16);
    repeat (16) cycle(1, 1, 5'($urandom_range(1, 18)), 5'($urandom_range(1, 18)));
    repeat (6) cycle(1, 0, 0, 0);

    // clear during WRITE of the SETTLE=1 instance, then a fresh request
    cycle(1, 1, 5'd9, 5'd10);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 5'd9, 5'd10);
    repeat (6) cycle(1, 0, 0, 0);

    // random traffic
    repeat (500) cycle(($urandom_range(0, 49) != 0), 1'($urandom),
                       5'($urandom_range(0, 27)), 5'($urandom_range(0, 27)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
